axis_unpack: RTL and testbench

// - AXI-stream width down-converter: accepts one DATA_WIDTH word on the slave

---
 rtl/axis_unpack.sv | 89 ++++++++
 tb/tb_axis_unpack.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/axis_unpack.sv
`default_nettype none
// ============================================================================
// Module      : axis_unpack
// Description : AXI-stream width down-converter. Splits each DATA_WIDTH word
//               into RATIO = DATA_WIDTH/OUT_WIDTH beats at full throughput.
//               Optional macro AXIS_UNPACK_TLAST_EN adds tlast pass-through.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_unpack #(
    parameter int DATA_WIDTH = 256,
    parameter int OUT_WIDTH  = 32,
    parameter int MSB_FIRST  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
`ifdef AXIS_UNPACK_TLAST_EN
    input  logic                  s_axis_tlast,
    output logic                  m_axis_tlast,
`endif
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [OUT_WIDTH-1:0]  m_axis_tdata
);

    localparam int RATIO  = DATA_WIDTH / OUT_WIDTH;
    localparam int BEAT_W = $clog2(RATIO);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(RATIO - 1);

    logic [DATA_WIDTH-1:0] hold_q;
    logic [BEAT_W-1:0]     beat_q;
    logic                  full_q;
    logic                  last_beat;
    logic                  s_hs;
    logic                  m_hs;
    logic [OUT_WIDTH-1:0]  slices [RATIO];

    // Slice order is fixed at elaboration, so the output mux only sees beat_q.
    for (genvar i = 0; i < RATIO; i++) begin : g_slice
        localparam int IDX = (MSB_FIRST != 0) ? (RATIO - 1 - i) : i;
        assign slices[i] = hold_q[IDX*OUT_WIDTH +: OUT_WIDTH];
    end

    assign last_beat     = (beat_q == BEAT_LAST);
    assign s_axis_tready = ~rst & (~full_q | (last_beat & m_axis_tready));
    assign s_hs          = s_axis_tvalid & s_axis_tready;
    assign m_hs          = full_q & m_axis_tready;

    // Outputs are forced low for the whole reset cycle, not just after the edge.
    assign m_axis_tvalid = full_q & ~rst;
    assign m_axis_tdata  = rst ? '0 : slices[beat_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q <= '0;
            beat_q <= '0;
            full_q <= 1'b0;
        end else if (s_hs) begin
            hold_q <= s_axis_tdata;
            beat_q <= '0;
            full_q <= 1'b1;
        end else if (m_hs) begin
            if (last_beat) begin
                beat_q <= '0;
                full_q <= 1'b0;
            end else begin
                beat_q <= beat_q + BEAT_W'(1);
            end
        end
    end

`ifdef AXIS_UNPACK_TLAST_EN
    logic tlast_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            tlast_q <= 1'b0;
        end else if (s_hs) begin
            tlast_q <= s_axis_tlast;
        end
    end

    assign m_axis_tlast = tlast_q & last_beat & ~rst;
`endif

endmodule
`default_nettype wire

// File: tb/tb_axis_unpack.sv
`default_nettype none
// ============================================================================
// Module      : tb_axis_unpack
// Description : Scoreboard bench for axis_unpack, LSB-first and MSB-first.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_unpack;

    localparam int DW = 64;
    localparam int OW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          s_last;
    logic          m_ready;

    logic          sa_ready, ma_valid, ma_last;
    logic [OW-1:0] ma_data;
    logic          sb_ready, mb_valid, mb_last;
    logic [OW-1:0] mb_data;

    int errors = 0;
    int checks = 0;

    logic [OW:0] qa [$];
    logic [OW:0] qb [$];

    always #5 clk = ~clk;

    axis_unpack #(.DATA_WIDTH(DW), .OUT_WIDTH(OW), .MSB_FIRST(0)) dut_a (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tvalid (s_valid),
        .s_axis_tready (sa_ready),
        .s_axis_tdata  (s_data),
`ifdef AXIS_UNPACK_TLAST_EN
        .s_axis_tlast  (s_last),
        .m_axis_tlast  (ma_last),
`endif
        .m_axis_tvalid (ma_valid),
        .m_axis_tready (m_ready),
        .m_axis_tdata  (ma_data)
    );

    axis_unpack #(.DATA_WIDTH(DW), .OUT_WIDTH(OW), .MSB_FIRST(1)) dut_b (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tvalid (s_valid),
        .s_axis_tready (sb_ready),
        .s_axis_tdata  (s_data),
`ifdef AXIS_UNPACK_TLAST_EN
        .s_axis_tlast  (s_last),
        .m_axis_tlast  (mb_last),
`endif
        .m_axis_tvalid (mb_valid),
        .m_axis_tready (m_ready),
        .m_axis_tdata  (mb_data)
    );

`ifndef AXIS_UNPACK_TLAST_EN
    assign ma_last = 1'b0;
    assign mb_last = 1'b0;
`endif

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected beats are queued as each wide word is accepted.
    always @(negedge clk) begin
        if (rst) begin
            qa.delete();
            qb.delete();
        end else begin
            if (s_valid && sa_ready)
                for (int k = 0; k < 4; k++)
                    qa.push_back({s_last && (k == 3), s_data[k*OW +: OW]});
            if (s_valid && sb_ready)
                for (int k = 0; k < 4; k++)
                    qb.push_back({s_last && (k == 3), s_data[(3-k)*OW +: OW]});
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (ma_valid && m_ready) begin
                if (qa.size() == 0) chk("a_unexpected_beat", {ma_last, ma_data}, 64'h1_FFFF_FFFF);
                else                chk("a_beat", {ma_last, ma_data}, qa.pop_front());
            end
            if (mb_valid && m_ready) begin
                if (qb.size() == 0) chk("b_unexpected_beat", {mb_last, mb_data}, 64'h1_FFFF_FFFF);
                else                chk("b_beat", {mb_last, mb_data}, qb.pop_front());
            end
        end
    end

    logic [DW-1:0] words [3];
    logic [OW-1:0] lsb_exp [4];
    logic [DW-1:0] w;

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b0;
        words   = '{64'hA003_A002_A001_A000, 64'hB003_B002_B001_B000, 64'hC003_C002_C001_C000};
        lsb_exp = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        repeat (3) tick();
        chk("rst_tvalid", ma_valid, 0);
        chk("rst_tdata",  ma_data,  0);
        chk("rst_tready", sa_ready, 0);
        rst = 1'b0;
        tick();
        chk("idle_tready", sa_ready, 1);

        // Single word, both slice orders.
        m_ready = 1'b1; s_valid = 1'b1; s_data = 64'h4444_3333_2222_1111;
        tick();
        s_valid = 1'b0;
        for (int b = 0; b < 4; b++) begin
            chk("single_valid", ma_valid, 1);
            chk("single_lsb",   ma_data,  lsb_exp[b]);
            chk("single_msb",   mb_data,  lsb_exp[3-b]);
            chk("single_tready", sa_ready, (b == 3) ? 1 : 0);
            tick();
        end
        chk("single_done", ma_valid, 0);

        // Back-to-back words, no gaps.
        s_valid = 1'b1; s_data = words[0];
        tick();
        for (int b = 0; b < 12; b++) begin
            w = words[b/4];
            chk("b2b_valid",  ma_valid, 1);
            chk("b2b_data",   ma_data,  w[(b%4)*OW +: OW]);
            chk("b2b_tready", sa_ready, (b % 4 == 3) ? 1 : 0);
            if (b % 4 == 3 && b < 11) s_data = words[b/4 + 1];
            if (b == 11) s_valid = 1'b0;
            tick();
        end
        chk("b2b_done", ma_valid, 0);

        // Backpressure on beat 2.
        s_valid = 1'b1; s_data = 64'hDDDD_CCCC_BBBB_AAAA;
        tick();
        s_data = 64'h0123_4567_89AB_CDEF;
        s_valid = 1'b0;
        tick();
        tick();
        s_valid = 1'b1;
        m_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            chk("bp_data",   ma_data,  16'hCCCC);
            chk("bp_valid",  ma_valid, 1);
            chk("bp_tready", sa_ready, 0);
            tick();
        end
        m_ready = 1'b1;
        chk("bp_resume", ma_data, 16'hCCCC);
        tick();
        chk("bp_beat3", ma_data, 16'hDDDD);
        chk("bp_beat3_tready", sa_ready, 1);
        tick();
        s_valid = 1'b0;
        repeat (4) tick();

        // Reset in the middle of a word.
        s_valid = 1'b1; s_data = 64'h8888_7777_6666_5555;
        tick();
        s_valid = 1'b0;
        tick();
        chk("mid_beat1", ma_data, 16'h6666);
        rst = 1'b1;
        chk("mid_rst_tready", sa_ready, 0);
        tick();
        rst = 1'b0;
        chk("mid_tvalid", ma_valid, 0);
        chk("mid_tdata",  ma_data,  0);
        s_valid = 1'b1; s_data = 64'hD004_D003_D002_D001;
        tick();
        s_valid = 1'b0;
        chk("mid_restart_a", ma_data, 16'hD001);
        chk("mid_restart_b", mb_data, 16'hD004);
        repeat (4) tick();

`ifdef AXIS_UNPACK_TLAST_EN
        // tlast only on the final slice of a last word.
        s_valid = 1'b1; s_last = 1'b0; s_data = 64'hE003_E002_E001_E000;
        tick();
        for (int b = 0; b < 8; b++) begin
            chk("tlast_a", ma_last, (b == 7) ? 1 : 0);
            chk("tlast_b", mb_last, (b == 7) ? 1 : 0);
            if (b == 3) begin
                s_last = 1'b1;
                s_data = 64'hF003_F002_F001_F000;
            end
            if (b == 7) s_valid = 1'b0;
            tick();
        end
        s_last = 1'b0;
        chk("tlast_idle", ma_last, 0);
`endif

        repeat (3) tick();
        chk("qa_drained", qa.size(), 0);
        chk("qb_drained", qb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
